hexcount_scan: RTL and testbench

Parametrised multi-digit hexadecimal counter with a time-multiplexed seven-segment scanner. It generalises the single-board 4-digit key counter to DIGITS digits and adds decrement, debounced and synchronised keys, a run-time scan-rate selector and a wrap indicator. It sits between the board push-buttons and the common-cathode digit grounds and segment lines.

---
 rtl/hexcount_scan.sv | 157 +++++++++++++++
 tb/tb_hexcount_scan.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/hexcount_scan.sv
// Multi-digit hex up/down counter driven by debounced push-buttons, with a
// time-multiplexed common-cathode seven-segment scanner and selectable scan rate.
module hexcount_scan #(
  parameter int unsigned         DIGITS          = 4,
  parameter int unsigned         DEBOUNCE_CYCLES = 50000,
  parameter int unsigned         SCAN_TAP0       = 15,
  parameter int unsigned         SCAN_TAP1       = 19,
  parameter int unsigned         SCAN_TAP2       = 25,
  parameter logic [4*DIGITS-1:0] INIT            = 16'hFFEA
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  key_one,
  input  logic                  key_two,
  input  logic                  key_zero,
  output logic [DIGITS-1:0]     grounds,
  output logic [6:0]            display,
  output logic [4*DIGITS-1:0]   value,
  output logic                  wrap
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned IW = $clog2(DIGITS);
  localparam logic [CW-1:0] CntLast = CW'(DEBOUNCE_CYCLES - 1);

  // Key order in the vectors below: bit 0 = increment, 1 = decrement, 2 = speed.
  logic [2:0]         keys_raw;
  logic [2:0]         sync1_q, sync2_q;
  logic [2:0]         deb_q, deb_d, deb_prev_q;
  logic [2:0][CW-1:0] cnt_q, cnt_d;
  logic [2:0]         press;

  logic [4*DIGITS-1:0] value_q, value_d;
  logic                wrap_q, wrap_d;
  logic [1:0]          speed_q, speed_d;
  logic [25:0]         div_q;
  logic [4:0]          tap;
  logic [25:0]         tap_mask;
  logic                tick;
  logic [IW-1:0]       idx_q, idx_d;
  logic [DIGITS-1:0]   grounds_q, grounds_d;
  logic [3:0]          nibble;

  assign keys_raw = {key_zero, key_two, key_one};

  // A differing sample advances the count; the level flips on the final one.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    for (int k = 0; k < 3; k++) begin
      if (sync2_q[k] != deb_q[k]) begin
        if (cnt_q[k] == CntLast) begin
          deb_d[k] = ~deb_q[k];
        end else begin
          cnt_d[k] = cnt_q[k] + 1'b1;
        end
      end
    end
  end

  assign press = deb_q & ~deb_prev_q;

  always_comb begin
    value_d = value_q;
    wrap_d  = 1'b0;
    if (press[0] && !press[1]) begin
      value_d = value_q + 1'b1;
      wrap_d  = &value_q;
    end else if (press[1] && !press[0]) begin
      value_d = value_q - 1'b1;
      wrap_d  = ~|value_q;
    end
  end

  always_comb begin
    speed_d = speed_q;
    if (press[2]) begin
      speed_d = (speed_q == 2'd2) ? 2'd0 : speed_q + 2'd1;
    end
  end

  always_comb begin
    case (speed_q)
      2'd1:    tap = 5'(SCAN_TAP1);
      2'd2:    tap = 5'(SCAN_TAP2);
      default: tap = 5'(SCAN_TAP0);
    endcase
  end

  assign tap_mask = (26'd1 << tap) - 26'd1;
  assign tick     = (div_q & tap_mask) == tap_mask;

  always_comb begin
    idx_d     = idx_q;
    grounds_d = grounds_q;
    if (tick) begin
      idx_d     = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      grounds_d = {grounds_q[DIGITS-2:0], grounds_q[DIGITS-1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      cnt_q      <= '0;
      value_q    <= INIT;
      wrap_q     <= 1'b0;
      speed_q    <= 2'd0;
      div_q      <= '0;
      idx_q      <= '0;
      grounds_q  <= ~DIGITS'(1);
    end else begin
      sync1_q    <= keys_raw;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      cnt_q      <= cnt_d;
      value_q    <= value_d;
      wrap_q     <= wrap_d;
      speed_q    <= speed_d;
      div_q      <= div_q + 26'd1;
      idx_q      <= idx_d;
      grounds_q  <= grounds_d;
    end
  end

  assign nibble = value_q[4*idx_q +: 4];

  always_comb begin
    case (nibble)
      4'h0:    display = 7'h7E;
      4'h1:    display = 7'h30;
      4'h2:    display = 7'h6D;
      4'h3:    display = 7'h79;
      4'h4:    display = 7'h33;
      4'h5:    display = 7'h5B;
      4'h6:    display = 7'h5F;
      4'h7:    display = 7'h70;
      4'h8:    display = 7'h7F;
      4'h9:    display = 7'h7B;
      4'hA:    display = 7'h77;
      4'hB:    display = 7'h1F;
      4'hC:    display = 7'h4E;
      4'hD:    display = 7'h3D;
      4'hE:    display = 7'h4F;
      default: display = 7'h47;
    endcase
  end

  assign grounds = grounds_q;
  assign value   = value_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_hexcount_scan.sv
// Directed bench for hexcount_scan: vector table for key presses plus
// hand-written sequences for latency, wrap, scan rate and mid-debounce reset.
module tb_hexcount_scan;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        key_one = 1'b0, key_two = 1'b0, key_zero = 1'b0;
  logic        kb_one = 1'b0, kb_two = 1'b0, kb_zero = 1'b0;
  logic [3:0]  grounds_a, grounds_b;
  logic [6:0]  display_a, display_b;
  logic [15:0] value_a, value_b;
  logic        wrap_a, wrap_b;

  int checks = 0;
  int failures = 0;
  int wrap_a_cnt = 0;

  always #5 clk = ~clk;

  hexcount_scan #(
    .DIGITS(4), .DEBOUNCE_CYCLES(4), .SCAN_TAP0(2), .SCAN_TAP1(3), .SCAN_TAP2(4),
    .INIT(16'hFFEA)
  ) dut_a (
    .clk(clk), .reset(reset), .key_one(key_one), .key_two(key_two), .key_zero(key_zero),
    .grounds(grounds_a), .display(display_a), .value(value_a), .wrap(wrap_a)
  );

  hexcount_scan #(
    .DIGITS(4), .DEBOUNCE_CYCLES(4), .SCAN_TAP0(2), .SCAN_TAP1(3), .SCAN_TAP2(4),
    .INIT(16'hFFFF)
  ) dut_b (
    .clk(clk), .reset(reset), .key_one(kb_one), .key_two(kb_two), .key_zero(kb_zero),
    .grounds(grounds_b), .display(display_b), .value(value_b), .wrap(wrap_b)
  );

  typedef struct {
    logic        k1;
    logic        k2;
    int          hold;
    logic [15:0] exp_val;
    int          exp_wraps;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (wrap_a === 1'b1) wrap_a_cnt++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic press_a(input logic k1, input logic k2, input logic kz, input int hold);
    key_one  = k1;
    key_two  = k2;
    key_zero = kz;
    steps(hold);
    key_one  = 1'b0;
    key_two  = 1'b0;
    key_zero = 1'b0;
    steps(10);
  endtask

  // Skips the (possibly partial) current dwell, then times one full dwell.
  task automatic measure_dwell(input string name, input int exp);
    logic [3:0] g;
    int n;
    bit seen;
    g = grounds_a;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (grounds_a !== g) seen = 1'b1;
    end
    g = grounds_a;
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      n++;
      if (grounds_a !== g) seen = 1'b1;
    end
    check(name, n, exp);
  endtask

  initial begin
    logic [6:0] disp_exp[4];
    logic [3:0] g_exp;
    int idx;

    disp_exp = '{7'h77, 7'h4F, 7'h47, 7'h47};
    vecs[0] = '{k1: 1'b1, k2: 1'b0, hold: 10, exp_val: 16'hFFEC, exp_wraps: 0};
    vecs[1] = '{k1: 1'b1, k2: 1'b0, hold: 10, exp_val: 16'hFFED, exp_wraps: 0};
    vecs[2] = '{k1: 1'b1, k2: 1'b0, hold: 3,  exp_val: 16'hFFED, exp_wraps: 0};
    vecs[3] = '{k1: 1'b1, k2: 1'b1, hold: 10, exp_val: 16'hFFED, exp_wraps: 0};
    vecs[4] = '{k1: 1'b0, k2: 1'b1, hold: 10, exp_val: 16'hFFEC, exp_wraps: 0};

    steps(2);
    reset = 1'b0;
    check("reset_value", value_a, 16'hFFEA);
    check("reset_wrap", wrap_a, 1'b0);
    check("reset_grounds", grounds_a, 4'b1110);
    check("reset_display", display_a, 7'h77);
    check("reset_value_b", value_b, 16'hFFFF);

    // Idle scan at speed 0: grounds advance on every 4th edge after reset release.
    for (int k = 1; k <= 16; k++) begin
      step();
      idx = (k / 4) % 4;
      g_exp = ~(4'b0001 << idx);
      check($sformatf("scan_grounds_%0d", k), grounds_a, g_exp);
      check($sformatf("scan_display_%0d", k), display_a, disp_exp[idx]);
    end
    check("idle_value", value_a, 16'hFFEA);
    check("idle_wrap_count", wrap_a_cnt, 0);

    // First increment lands exactly on edge 7 after the key goes high.
    wrap_a_cnt = 0;
    key_one = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step();
      if (e == 6) check("latency_edge6", value_a, 16'hFFEA);
      if (e == 7) check("latency_edge7", value_a, 16'hFFEB);
    end
    steps(3);
    key_one = 1'b0;
    steps(10);
    check("press1_value", value_a, 16'hFFEB);
    check("press1_wraps", wrap_a_cnt, 0);

    for (int r = 0; r < 5; r++) begin
      wrap_a_cnt = 0;
      press_a(vecs[r].k1, vecs[r].k2, 1'b0, vecs[r].hold);
      check($sformatf("vec%0d_value", r), value_a, vecs[r].exp_val);
      check($sformatf("vec%0d_wraps", r), wrap_a_cnt, vecs[r].exp_wraps);
    end

    // Full-width wrap in both directions on the all-F instance.
    kb_one = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      if (e == 6) begin
        check("inc_wrap_pre_value", value_b, 16'hFFFF);
        check("inc_wrap_pre_flag", wrap_b, 1'b0);
      end
      if (e == 7) begin
        check("inc_wrap_value", value_b, 16'h0000);
        check("inc_wrap_flag", wrap_b, 1'b1);
      end
      if (e == 8) check("inc_wrap_flag_drop", wrap_b, 1'b0);
    end
    steps(2);
    kb_one = 1'b0;
    steps(10);
    kb_two = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      if (e == 6) check("dec_wrap_pre_flag", wrap_b, 1'b0);
      if (e == 7) begin
        check("dec_wrap_value", value_b, 16'hFFFF);
        check("dec_wrap_flag", wrap_b, 1'b1);
      end
      if (e == 8) check("dec_wrap_flag_drop", wrap_b, 1'b0);
    end
    steps(2);
    kb_two = 1'b0;
    steps(10);
    check("dec_wrap_final", value_b, 16'hFFFF);

    measure_dwell("dwell_speed0", 4);
    press_a(1'b0, 1'b0, 1'b1, 10);
    measure_dwell("dwell_speed1", 8);
    press_a(1'b0, 1'b0, 1'b1, 10);
    measure_dwell("dwell_speed2", 16);
    press_a(1'b0, 1'b0, 1'b1, 10);
    measure_dwell("dwell_speed0_again", 4);
    check("speed_value", value_a, 16'hFFEC);

    // Reset in the middle of a debounce, key kept held through and after it.
    key_one = 1'b1;
    steps(3);
    reset = 1'b1;
    #1;
    check("midreset_value", value_a, 16'hFFEA);
    check("midreset_grounds", grounds_a, 4'b1110);
    check("midreset_wrap", wrap_a, 1'b0);
    steps(2);
    reset = 1'b0;
    wrap_a_cnt = 0;
    for (int e = 1; e <= 7; e++) begin
      step();
      if (e == 6) check("postreset_edge6", value_a, 16'hFFEA);
      if (e == 7) check("postreset_edge7", value_a, 16'hFFEB);
    end
    steps(10);
    key_one = 1'b0;
    steps(10);
    check("postreset_final", value_a, 16'hFFEB);
    check("postreset_wraps", wrap_a_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
